// File: rtl/port_power_detector.sv
// port_power_detector: windowed |I|^2+|Q|^2 power detector for the receive port of a
// swept filter measurement. Sums 2^LOG_N accepted samples and presents one unsigned power
// word per window through a valid/ready handshake, with a full-scale sample flag.
// Optional peak-hold of delivered power words is enabled by defining
// PORT_POWER_DETECTOR_PEAK_HOLD_EN; otherwise p_peak reads 0 and peak_clr is ignored.
module port_power_detector #(
  parameter int DW    = 12,
  parameter int LOG_N = 8,
  parameter int ACC_W = 2*DW+LOG_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_i,
  input  logic signed [DW-1:0] s_q,
  output logic                 p_valid,
  input  logic                 p_ready,
  output logic [ACC_W-1:0]     p_pow,
  output logic                 p_over,
  input  logic                 peak_clr,
  output logic [ACC_W-1:0]     p_peak
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_t;

  localparam logic signed [DW-1:0] FULL_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [LOG_N-1:0]     CNT_ONE  = 1;

  // Both squares are at most 2^(2*DW-2), so their sum fits 2*DW unsigned bits.
  function automatic logic [2*DW-1:0] f_mag_sq(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ea, eb, pa, pb;
    ea = a;
    eb = b;
    pa = ea * ea;
    pb = eb * eb;
    return $unsigned(pa) + $unsigned(pb);
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_s_ready;
  logic [LOG_N-1:0]   r_cnt;
  logic               r_drn;
  logic               r_over_acc;
  logic               r_vld_p1;
  logic [2*DW-1:0]    r_sq_p1;
  logic [ACC_W-1:0]   r_acc_p2;
  logic               w_accept;
  logic               w_last;
  logic               w_full;
  logic               w_start_acc;
  logic               w_flush;
  logic               w_load;
  logic [ACC_W-1:0]   w_sq_ext;

  assign s_ready     = r_s_ready;
  assign busy        = (r_state == S_ACC) || (r_state == S_HOLD);
  assign w_accept    = s_valid && r_s_ready;
  assign w_last      = w_accept && (r_cnt == '1);
  assign w_full      = (s_i == FULL_NEG) || (s_q == FULL_NEG);
  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_flush     = abort && ((r_state == S_ACC) || (r_state == S_DRAIN));
  // The result registers latch once, on the first HOLD cycle, after the pipeline drained.
  assign w_load      = (r_state == S_HOLD) && !p_valid && !abort;
  assign w_sq_ext    = ACC_W'(r_sq_p1);

  // Next-state logic; abort takes priority over every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !abort) w_state_nxt = S_ACC;
      S_ACC:   if (abort) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (abort) w_state_nxt = S_IDLE;
               else if (r_drn) w_state_nxt = S_HOLD;
      S_HOLD:  if (abort || (p_valid && p_ready)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Window control: ready, sample count, drain timer, overload flag, result valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready  <= 1'b0;
      r_cnt      <= '0;
      r_drn      <= 1'b0;
      r_over_acc <= 1'b0;
      r_vld_p1   <= 1'b0;
      p_valid    <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt == S_ACC);
      r_drn     <= (r_state == S_DRAIN) && (w_state_nxt == S_DRAIN);
      r_vld_p1  <= w_accept && !abort;
      if (w_start_acc)   r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + CNT_ONE;
      if (w_start_acc)             r_over_acc <= 1'b0;
      else if (w_accept && w_full) r_over_acc <= 1'b1;
      if (abort || (p_valid && p_ready)) p_valid <= 1'b0;
      else if (r_state == S_HOLD)        p_valid <= 1'b1;
    end
  end

  // ---- stage p1: square the accepted sample ----
  // Data-only register, qualified by r_vld_p1.
  always_ff @(posedge clk) begin
    if (w_accept) r_sq_p1 <= f_mag_sq(s_i, s_q);
  end

  // ---- stage p2: accumulate; cleared when a window opens ----
  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_p2 <= '0;
      p_pow    <= '0;
      p_over   <= 1'b0;
    end else begin
      if (w_start_acc)               r_acc_p2 <= '0;
      else if (r_vld_p1 && !w_flush) r_acc_p2 <= r_acc_p2 + w_sq_ext;
      if (w_load) begin
        p_pow  <= r_acc_p2;
        p_over <= r_over_acc;
      end
    end
  end

`ifdef PORT_POWER_DETECTOR_PEAK_HOLD_EN
  // Peak hold of delivered power words; clear beats a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       p_peak <= '0;
    else if (peak_clr)                                p_peak <= '0;
    else if (p_valid && p_ready && (p_pow > p_peak))  p_peak <= p_pow;
  end
`else
  logic w_unused_peak_clr;
  assign w_unused_peak_clr = peak_clr;
  assign p_peak            = '0;
`endif

endmodule
